// File: rtl/mem_arbiter_if.sv
// Request-unit / RAM side signal bundle for the memory arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // request unit side
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              iwait;
  logic              dwait;
  logic [DATA_W-1:0] iload;
  logic [DATA_W-1:0] dload;
  logic              err;
  // RAM side
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic [1:0]        ramstate;

  // arbiter view
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, err, ramREN, ramWEN, ramaddr, ramstore
  );

  // requester + RAM view
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, err, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetches and data accesses onto a single-ported RAM.
// Data wins in IDLE unless the instruction side has been passed over
// STARVE_MAX times in a row. Wait releases, loads and RAM strobes are
// combinational from the registered state so completion lands in the same
// cycle the RAM reports ACCESS/ERROR.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic            CLK,
  input logic            nRST,
  mem_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W = (STARVE_MAX == 0) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, ISERVE, DSERVE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] store_q, store_n;
  logic              wr_q, wr_n;
  logic [CNT_W-1:0]  starve_cnt, starve_n;

  logic d_pend;
  logic ram_done;
  logic ram_err;
  logic i_turn;

  assign d_pend   = bus.dREN | bus.dWEN;
  assign ram_err  = (bus.ramstate == RAM_ERROR);
  assign ram_done = (bus.ramstate == RAM_ACCESS) | ram_err;
  // instruction wins when data is idle or its fairness budget is used up
  assign i_turn   = bus.iREN &
                    (~d_pend | ((STARVE_MAX != 0) && (starve_cnt == CNT_MAX)));

  // state and latched request registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      addr_q     <= '0;
      store_q    <= '0;
      wr_q       <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state      <= state_n;
      addr_q     <= addr_n;
      store_q    <= store_n;
      wr_q       <= wr_n;
      starve_cnt <= starve_n;
    end
  end

  // grant decision, RAM strobes and completion handshakes
  always_comb begin
    state_n      = state;
    addr_n       = addr_q;
    store_n      = store_q;
    wr_n         = wr_q;
    starve_n     = starve_cnt;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.err      = 1'b0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;

    case (state)
      IDLE: begin
        if (i_turn) begin
          state_n = ISERVE;
          addr_n  = bus.iaddr;
        end else if (d_pend) begin
          state_n = DSERVE;
          addr_n  = bus.daddr;
          store_n = bus.dstore;
          wr_n    = bus.dWEN;
        end
      end

      ISERVE: begin
        if (!bus.iREN) begin
          // requester withdrew: drop strobe, no release, count untouched
          state_n = IDLE;
        end else begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = addr_q;
          if (ram_done) begin
            bus.iwait = 1'b0;
            bus.iload = bus.ramload;
            bus.err   = ram_err;
            starve_n  = '0;
            state_n   = IDLE;
          end
        end
      end

      DSERVE: begin
        if (!d_pend) begin
          state_n = IDLE;
        end else begin
          bus.ramWEN   = wr_q;
          bus.ramREN   = ~wr_q;
          bus.ramaddr  = addr_q;
          bus.ramstore = store_q;
          if (ram_done) begin
            bus.dwait = 1'b0;
            bus.dload = wr_q ? '0 : bus.ramload;
            bus.err   = ram_err;
            if (!bus.iREN)
              starve_n = '0;
            else if (starve_cnt != CNT_MAX)
              starve_n = starve_cnt + CNT_W'(1);
            state_n = IDLE;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed handshake cases, grant-order checks for
// STARVE_MAX=4 and 0, then random traffic scored against a word-level model.
module tb_mem_arbiter;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;
  localparam int unsigned N_TXN = 120;

  typedef struct packed {
    logic        wr;
    logic [31:0] data;
  } dexp_t;

  logic CLK;
  logic nRST;
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  bit   ram_stop = 1'b0;

  logic [31:0] iq[$];
  dexp_t       dq[$];
  logic [31:0] ram_mem[16];
  logic [31:0] ref_mem[16];

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(0)) dut0 (
    .CLK(CLK), .nRST(nRST), .bus(bus0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return int'((a >> 2) & 32'hF);
  endfunction

  // scoreboard: pop expected responses whenever a wait is released
  always @(negedge CLK) begin
    if (mon_en) begin
      if (!bus.iwait) begin
        chk1("i_release_expected", iq.size() > 0, 1'b1);
        if (iq.size() > 0) chk("iload", bus.iload, iq.pop_front());
      end else begin
        chk("iload_idle", bus.iload, 32'h0);
      end
      if (!bus.dwait) begin
        chk1("d_release_expected", dq.size() > 0, 1'b1);
        if (dq.size() > 0) begin
          dexp_t e;
          e = dq.pop_front();
          chk1("d_is_write", bus.ramWEN, e.wr);
          if (!e.wr) chk("dload", bus.dload, e.data);
        end
      end
      chk1("err", bus.err, (bus.ramstate == ERROR) && (bus.ramREN || bus.ramWEN));
      chk1("single_release", !bus.iwait && !bus.dwait, 1'b0);
    end
  end

  // RAM: random BUSY count, occasional ERROR, word memory for data region
  task automatic ram_model();
    int unsigned busy = 0;
    bit active = 1'b0;
    while (!ram_stop) begin
      @(posedge CLK);
      #2;
      if (bus.ramREN || bus.ramWEN) begin
        if (!active) begin
          active = 1'b1;
          busy = $urandom_range(0, 2);
        end
        if (busy > 0) begin
          busy--;
          bus.ramstate = BUSY;
        end else begin
          bus.ramstate = ($urandom_range(0, 7) == 0) ? ERROR : ACCESS;
          active = 1'b0;
          if (bus.ramWEN) ram_mem[widx(bus.ramaddr)] = bus.ramstore;
        end
        if (bus.ramWEN) bus.ramload = $urandom;
        else if (bus.ramaddr < 32'h1000) bus.ramload = rom_word(bus.ramaddr);
        else bus.ramload = ram_mem[widx(bus.ramaddr)];
      end else begin
        active = 1'b0;
        bus.ramstate = FREE;
        bus.ramload = $urandom;
      end
    end
    bus.ramstate = FREE;
  endtask

  task automatic i_req(input int unsigned n);
    for (int k = 0; k < int'(n); k++) begin
      int unsigned gap;
      int t;
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        bus.iREN = 1'b0;
        repeat (gap) step();
      end
      bus.iREN  = 1'b1;
      bus.iaddr = 32'($urandom_range(0, 1023)) << 2;
      iq.push_back(rom_word(bus.iaddr));
      t = 0;
      do begin
        @(negedge CLK);
        t++;
      end while (bus.iwait !== 1'b0 && t < 80);
      chk1("i_done_in_time", bus.iwait, 1'b0);
      step();
    end
    bus.iREN = 1'b0;
  endtask

  task automatic d_req(input int unsigned n);
    for (int k = 0; k < int'(n); k++) begin
      int unsigned gap, kind, idx;
      int t;
      dexp_t e;
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
        repeat (gap) step();
      end
      kind = $urandom_range(0, 3);
      idx  = $urandom_range(0, 15);
      bus.daddr  = 32'h1000 + (32'(idx) << 2);
      bus.dstore = $urandom;
      bus.dREN   = (kind != 1);
      bus.dWEN   = (kind == 1) || (kind == 2);
      e.wr = bus.dWEN;
      if (bus.dWEN) begin
        ref_mem[idx] = bus.dstore;
        e.data = 32'h0;
      end else begin
        e.data = ref_mem[idx];
      end
      dq.push_back(e);
      t = 0;
      do begin
        @(negedge CLK);
        t++;
      end while (bus.dwait !== 1'b0 && t < 80);
      chk1("d_done_in_time", bus.dwait, 1'b0);
      step();
    end
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
  endtask

  initial begin
    int ng, cyc, scnt, n0_i, n0_all;
    bit exp_i;

    nRST = 1'b0;
    bus.iREN = 1'b0;  bus.iaddr = '0;  bus.dREN = 1'b0;  bus.dWEN = 1'b0;
    bus.daddr = '0;   bus.dstore = '0; bus.ramload = '0; bus.ramstate = FREE;
    bus0.iREN = 1'b0; bus0.iaddr = '0; bus0.dREN = 1'b0; bus0.dWEN = 1'b0;
    bus0.daddr = '0;  bus0.dstore = '0; bus0.ramload = '0; bus0.ramstate = FREE;
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = 32'(i) * 32'h0101_0101;
      ref_mem[i] = 32'(i) * 32'h0101_0101;
    end

    // reset values
    @(negedge CLK);
    chk1("rst_iwait", bus.iwait, 1'b1);
    chk1("rst_dwait", bus.dwait, 1'b1);
    chk1("rst_ramREN", bus.ramREN, 1'b0);
    chk1("rst_ramWEN", bus.ramWEN, 1'b0);
    chk("rst_ramaddr", bus.ramaddr, 32'h0);
    chk("rst_ramstore", bus.ramstore, 32'h0);
    chk("rst_iload", bus.iload, 32'h0);
    chk1("rst_err", bus.err, 1'b0);
    step();
    nRST = 1'b1;
    step();

    // single instruction read, one-cycle RAM
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    @(negedge CLK);
    chk1("rd_idle_ramREN", bus.ramREN, 1'b0);
    step();
    bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
    @(negedge CLK);
    chk1("rd_ramREN", bus.ramREN, 1'b1);
    chk("rd_ramaddr", bus.ramaddr, 32'h40);
    chk1("rd_iwait", bus.iwait, 1'b0);
    chk("rd_iload", bus.iload, 32'hDEADBEEF);
    step();
    bus.iREN = 1'b0; bus.ramstate = FREE;
    @(negedge CLK);
    chk1("rd_after_iwait", bus.iwait, 1'b1);
    chk("rd_after_iload", bus.iload, 32'h0);

    // write with two BUSY cycles; mid-service request changes ignored
    step();
    bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h1234;
    step();
    bus.ramstate = BUSY;
    @(negedge CLK);
    chk1("wr_b1_ramWEN", bus.ramWEN, 1'b1);
    chk("wr_b1_ramstore", bus.ramstore, 32'h1234);
    chk1("wr_b1_dwait", bus.dwait, 1'b1);
    step();
    bus.daddr = 32'h99; bus.dstore = 32'h5555;
    @(negedge CLK);
    chk1("wr_b2_ramWEN", bus.ramWEN, 1'b1);
    chk("wr_b2_ramaddr", bus.ramaddr, 32'h80);
    step();
    bus.ramstate = ACCESS;
    @(negedge CLK);
    chk1("wr_acc_ramWEN", bus.ramWEN, 1'b1);
    chk1("wr_acc_ramREN", bus.ramREN, 1'b0);
    chk("wr_acc_ramstore", bus.ramstore, 32'h1234);
    chk1("wr_acc_dwait", bus.dwait, 1'b0);
    chk1("wr_acc_err", bus.err, 1'b0);
    step();
    bus.dWEN = 1'b0; bus.ramstate = FREE;
    @(negedge CLK);
    chk1("wr_after_dwait", bus.dwait, 1'b1);

    // grant order with both sides held: fairness every STARVE_MAX data grants
    step();
    bus.iREN = 1'b1;  bus.iaddr = 32'h10; bus.dREN = 1'b1;  bus.daddr = 32'h20;
    bus0.iREN = 1'b1; bus0.iaddr = 32'h10; bus0.dREN = 1'b1; bus0.daddr = 32'h20;
    ng = 0; cyc = 0; scnt = 0; n0_i = 0; n0_all = 0;
    while (ng < 10 && cyc < 60) begin
      step();
      cyc++;
      bus.ramstate  = (bus.ramREN || bus.ramWEN) ? ACCESS : FREE;
      bus0.ramstate = (bus0.ramREN || bus0.ramWEN) ? ACCESS : FREE;
      @(negedge CLK);
      if (bus.ramREN || bus.ramWEN) begin
        exp_i = (scnt == 4);
        chk1($sformatf("grant_%0d_is_instr", ng), bus.ramaddr == 32'h10, exp_i);
        scnt = exp_i ? 0 : scnt + 1;
        ng++;
      end
      if (bus0.ramREN || bus0.ramWEN) begin
        n0_all++;
        if (bus0.ramaddr == 32'h10) n0_i++;
      end
    end
    chk("grants_seen", 32'(ng), 32'd10);
    chk("strict_instr_grants", 32'(n0_i), 32'd0);
    chk1("strict_data_grants", n0_all >= 10, 1'b1);
    step();
    bus.iREN = 1'b0;  bus.dREN = 1'b0;  bus.ramstate = FREE;
    bus0.iREN = 1'b0; bus0.dREN = 1'b0; bus0.ramstate = FREE;
    step();

    // abort of a data read in its second BUSY cycle, then pending fetch errors
    bus.dREN = 1'b1; bus.daddr = 32'h44; bus.iREN = 1'b1; bus.iaddr = 32'h50;
    step();
    bus.ramstate = BUSY;
    @(negedge CLK);
    chk1("ab_b1_ramREN", bus.ramREN, 1'b1);
    chk("ab_b1_ramaddr", bus.ramaddr, 32'h44);
    step();
    bus.dREN = 1'b0;
    @(negedge CLK);
    chk1("ab_ramREN_drop", bus.ramREN, 1'b0);
    chk1("ab_dwait", bus.dwait, 1'b1);
    step();
    bus.ramstate = FREE;
    @(negedge CLK);
    chk1("ab_idle_ramREN", bus.ramREN, 1'b0);
    chk1("ab_idle_dwait", bus.dwait, 1'b1);
    step();
    bus.ramstate = ERROR; bus.ramload = 32'hCAFE0001;
    @(negedge CLK);
    chk("er_ramaddr", bus.ramaddr, 32'h50);
    chk1("er_iwait", bus.iwait, 1'b0);
    chk1("er_err", bus.err, 1'b1);
    chk("er_iload", bus.iload, 32'hCAFE0001);
    step();
    bus.iREN = 1'b0; bus.ramstate = FREE;
    @(negedge CLK);
    chk1("er_after_err", bus.err, 1'b0);
    chk1("er_after_ramREN", bus.ramREN, 1'b0);

    // both data flags: write wins
    step();
    bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h60; bus.dstore = 32'h77;
    step();
    bus.ramstate = ACCESS;
    @(negedge CLK);
    chk1("both_ramWEN", bus.ramWEN, 1'b1);
    chk1("both_ramREN", bus.ramREN, 1'b0);
    chk("both_ramstore", bus.ramstore, 32'h77);
    chk1("both_dwait", bus.dwait, 1'b0);
    step();
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = FREE;

    // reset asserted mid-write
    step();
    bus.dWEN = 1'b1; bus.daddr = 32'h84; bus.dstore = 32'h9;
    step();
    bus.ramstate = BUSY;
    @(negedge CLK);
    chk1("mr_ramWEN_before", bus.ramWEN, 1'b1);
    #2;
    nRST = 1'b0;
    #1;
    chk1("mr_ramWEN", bus.ramWEN, 1'b0);
    chk1("mr_dwait", bus.dwait, 1'b1);
    chk("mr_ramaddr", bus.ramaddr, 32'h0);
    step();
    bus.dWEN = 1'b0; bus.ramstate = FREE;
    nRST = 1'b1;
    @(negedge CLK);
    chk1("mr_after_ramWEN", bus.ramWEN, 1'b0);
    chk1("mr_after_dwait", bus.dwait, 1'b1);
    step();

    // random traffic against the reference model
    mon_en = 1'b1;
    fork
      begin
        fork
          i_req(N_TXN);
          d_req(N_TXN);
        join
        ram_stop = 1'b1;
      end
      ram_model();
    join
    repeat (3) step();
    mon_en = 1'b0;
    chk("iq_drained", 32'(iq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);
    for (int i = 0; i < 16; i++)
      chk($sformatf("mem_%0d", i), ram_mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
